instr_fetcher: RTL
==================

# instr_fetcher

Instruction fetch unit feeding the decode/issue stage of the out-of-order RISC-V core. It holds the fetch PC and looks it up in a small direct-mapped instruction cache. On a miss it requests the word from the memory controller, then presents one instruction at a time to the decoder. It advances to the decoder's predicted PC on issue and redirects to the RoB's PC on a mispredict clear.

## Interface
Parameters:
- ICACHE_INDEX_WIDTH, 4, log2 of cache lines (one 32-bit word per line)
- RESET_PC, 32'h0, fetch address after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state is frozen
- rob_clear  in  1  mispredict flush from RoB
- rob_new_pc  in  32  redirect target, valid with rob_clear
- instr_ready  out  1  instr_out/instr_addr_out are valid
- instr_out  out  32  instruction word to decoder
- instr_addr_out  out  32  PC of instr_out
- instr_issued  in  1  decoder consumed the presented instruction this cycle
- predict_pc  in  32  next PC from decoder/predictor, valid while instr_ready
- mem_req  out  1  word-fetch request to memory controller
- mem_addr  out  32  word-aligned request address
- mem_data_valid  in  1  one-cycle pulse: mem_data holds the word for mem_addr
- mem_data  in  32  returned instruction word

## Operation
- Address split:
  - index = pc[ICACHE_INDEX_WIDTH+1:2]
  - tag = pc[31:ICACHE_INDEX_WIDTH+2]
  - pc[1:0] is always 0; compressed instructions are not supported.
- States:
  - FETCH: combinational cache lookup on pc.
    - Hit: register word and pc into the outputs, set instr_ready, go to PRESENT.
    - Miss: set mem_req=1 and mem_addr=pc, go to WAIT_MEM.
  - WAIT_MEM: hold mem_req and mem_addr stable.
    - On mem_data_valid: write the line (valid=1, tag, data), register mem_data and pc to the outputs, set instr_ready, drop mem_req, go to PRESENT.
  - PRESENT: outputs stay stable until instr_issued.
    - On instr_issued: pc <= predict_pc, clear instr_ready, go to FETCH.
  - DISCARD: entered when a clear arrives during WAIT_MEM.
    - Keep mem_req high until mem_data_valid.
    - On mem_data_valid: fill the cache with the old address's word, do not present it, go to FETCH at the redirected pc.
- rob_clear has priority over every other event in every state.
  - Set pc <= rob_new_pc and instr_ready <= 0.
  - If in WAIT_MEM, go to DISCARD. If already in DISCARD, stay in DISCARD. Otherwise go to FETCH.
  - Any instr_issued in the same cycle is ignored.
- A clear that arrives in the same cycle as mem_data_valid, in WAIT_MEM or DISCARD: fill the cache, present nothing, go to FETCH at rob_new_pc.
- rdy low: no register, cache, or state changes; outputs hold their values.

## Timing
- Reset values: state FETCH, pc=RESET_PC, all cache valid bits 0, instr_ready=0, instr_out=0, instr_addr_out=0, mem_req=0, mem_addr=0.
- Hit latency: instr_ready rises 1 cycle after entering FETCH. Issue-to-next-ready on a hit is 2 cycles.
- Miss latency: mem_req rises 1 cycle after entering FETCH. instr_ready rises on the cycle after mem_data_valid.
- instr_issued is sampled only while instr_ready=1; it is ignored otherwise.
- instr_out, instr_addr_out and predict_pc must not change while instr_ready=1 and instr_issued=0.
- mem_req is a level request. It stays high from request until the mem_data_valid cycle and is low the next cycle.

## Structure
- Shared package/config:
  - state encodings FETCH, WAIT_MEM, PRESENT, DISCARD
  - RESET_PC default
- Sub-module icache:
  - direct-mapped, parameterised by ICACHE_INDEX_WIDTH
  - combinational read: hit, data
  - synchronous write port: index, tag, data
  - synchronous clear of valid bits on rst
- Top level: FSM, pc register, output registers.

## Test plan
- Cold miss: after reset, memory returns 32'h00000093 four cycles after mem_req. Required: mem_req with mem_addr=0; instr_ready with instr_out=32'h00000093 and instr_addr_out=0 on the cycle after mem_data_valid.
- Hit path: issue at pc 0 with predict_pc=4, word 4 already cached. Required: instr_ready 2 cycles after issue, instr_addr_out=4, mem_req stays 0.
- Backpressure: instr_issued held 0 for 10 cycles. Required: instr_ready=1 and instr_out/instr_addr_out unchanged throughout; pc does not advance.
- Clear during miss: rob_clear with rob_new_pc=32'h100 while in WAIT_MEM for addr 8. Required: mem_req held until mem_data_valid; word cached at index 2 and not presented; next request has mem_addr=32'h100.
- Clear and issue together in PRESENT with predict_pc=32'h40 and rob_new_pc=32'h80. Required: next fetch address is 32'h80.
- Aliasing: fetch 32'h0 then 32'h40 (same index, ICACHE_INDEX_WIDTH=4), then 32'h0 again. Required: the third fetch misses and issues mem_req.
- rdy low: rdy low for 5 cycles mid-WAIT_MEM. Required: state, mem_req and mem_addr unchanged; operation resumes correctly when rdy returns high.

Source files
------------

// File: rtl/instr_fetcher_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the FSM state encoding and the default reset PC.
package instr_fetcher_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_MEM = 2'd1,
    PRESENT  = 2'd2,
    DISCARD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetcher_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational lookup, synchronous fill, valid bits cleared on rst.
module instr_fetcher_icache #(
  parameter int IW = 4,
  parameter int TW = 30 - IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_index,
  input  logic [TW-1:0] rd_tag,
  output logic          hit,
  output logic [31:0]   rd_data,
  input  logic          we,
  input  logic [IW-1:0] wr_index,
  input  logic [TW-1:0] wr_tag,
  input  logic [31:0]   wr_data
);

  localparam int LINES = 1 << IW;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Lookup: a line hits when it is valid and its tag matches.
  always_comb begin
    hit     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    rd_data = data_q[rd_index];
  end

  // Valid bits reset; a fill overwrites the whole line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage need no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetch unit: PC register, icache lookup, miss handling,
// and a one-instruction presentation register for the decoder.
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter int          ICACHE_INDEX_WIDTH = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  output logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  input  logic        instr_issued,
  input  logic [31:0] predict_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_data
);

  localparam int IW = ICACHE_INDEX_WIDTH;
  localparam int TW = 30 - IW;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         ready_q, ready_d;
  logic [31:0]  out_q, out_d;
  logic [31:0]  oaddr_q, oaddr_d;
  logic         req_q, req_d;
  logic [31:0]  maddr_q, maddr_d;
  logic         fill;
  logic         hit;
  logic [31:0]  hit_data;

  instr_fetcher_icache #(
    .IW (IW),
    .TW (TW)
  ) u_icache (
    .clk      (clk),
    .rst      (rst),
    .rd_index (pc_q[IW+1:2]),
    .rd_tag   (pc_q[31:IW+2]),
    .hit      (hit),
    .rd_data  (hit_data),
    .we       (fill && rdy),
    .wr_index (maddr_q[IW+1:2]),
    .wr_tag   (maddr_q[31:IW+2]),
    .wr_data  (mem_data)
  );

  // Next-state, PC and output-register logic; clear beats everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ready_d = ready_q;
    out_d   = out_q;
    oaddr_d = oaddr_q;
    req_d   = req_q;
    maddr_d = maddr_q;
    fill    = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (rob_clear) begin
          pc_d    = rob_new_pc;
          ready_d = 1'b0;
        end else if (hit) begin
          out_d   = hit_data;
          oaddr_d = pc_q;
          ready_d = 1'b1;
          state_d = PRESENT;
        end else begin
          req_d   = 1'b1;
          maddr_d = pc_q;
          state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        fill = mem_data_valid;
        if (rob_clear) begin
          pc_d    = rob_new_pc;
          ready_d = 1'b0;
          if (mem_data_valid) begin
            req_d   = 1'b0;
            state_d = FETCH;
          end else begin
            state_d = DISCARD;
          end
        end else if (mem_data_valid) begin
          out_d   = mem_data;
          oaddr_d = pc_q;
          ready_d = 1'b1;
          req_d   = 1'b0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (rob_clear) begin
          pc_d    = rob_new_pc;
          ready_d = 1'b0;
          state_d = FETCH;
        end else if (instr_issued) begin
          pc_d    = predict_pc;
          ready_d = 1'b0;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        fill = mem_data_valid;
        if (rob_clear) begin
          pc_d    = rob_new_pc;
          ready_d = 1'b0;
        end
        if (mem_data_valid) begin
          req_d   = 1'b0;
          state_d = FETCH;
        end
      end
    endcase
  end

  // State registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ready_q <= 1'b0;
      out_q   <= '0;
      oaddr_q <= '0;
      req_q   <= 1'b0;
      maddr_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      oaddr_q <= oaddr_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
    end
  end

  assign instr_ready    = ready_q;
  assign instr_out      = out_q;
  assign instr_addr_out = oaddr_q;
  assign mem_req        = req_q;
  assign mem_addr       = maddr_q;

endmodule
